// File: rtl/maze_controller.sv
// Sequencing FSM for the rat-in-maze datapath: depth-first search from (0,0) to (15,15),
// then drains the path stack into the move queue and replays the moves.
module maze_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir_ends,
  input  logic       arrive_final,
  input  logic       wall,
  input  logic       stack_empty,
  input  logic       q_empty,
  input  logic       xy_select,
  input  logic       mem_dout,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_dir,
  output logic       ld_n_x,
  output logic       ld_n_y,
  output logic       rst_x,
  output logic       rst_y,
  output logic       rst_dir,
  output logic       rst_n_x,
  output logic       rst_n_y,
  output logic [1:0] dir_select,
  output logic       mem_select,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  output logic       stack_rd,
  output logic       stack_wr,
  output logic       q_rd,
  output logic       q_wr,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       move_valid
);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT, S_CHECK, S_PROBE, S_BOUND, S_EVAL, S_MOVE, S_MARK,
    S_NEXT_DIR, S_BACK, S_BACK_DIR, S_BACK_MOVE, S_RESTORE,
    S_D_POP, S_D_PUSH, S_REPLAY, S_R_OUT, S_DONE, S_FAIL
  } state_t;

  typedef struct packed {
    logic init;
    logic probe;
    logic bound;
    logic move;
    logic mark;
    logic next_dir;
    logic back;
    logic back_dir;
    logic back_move;
    logic restore;
    logic d_pop;
    logic d_push;
    logic replay;
    logic r_out;
    logic done;
    logic fail;
    logic busy;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic   adv_dir;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: if (start) state_d = S_INIT;
      S_INIT:      state_d = S_CHECK;
      S_CHECK:     state_d = arrive_final ? S_D_POP : S_PROBE;
      S_PROBE:     state_d = S_BOUND;
      S_BOUND:     state_d = wall ? S_NEXT_DIR : S_EVAL;
      S_EVAL:      state_d = mem_dout ? S_NEXT_DIR : S_MOVE;
      S_MOVE:      state_d = S_MARK;
      S_MARK:      state_d = S_CHECK;
      S_NEXT_DIR:  state_d = dir_ends ? S_BACK : S_PROBE;
      S_BACK:      state_d = stack_empty ? S_FAIL : S_BACK_DIR;
      S_BACK_DIR:  state_d = S_BACK_MOVE;
      S_BACK_MOVE: state_d = S_RESTORE;
      S_RESTORE:   state_d = S_NEXT_DIR;
      S_D_POP:     state_d = stack_empty ? S_REPLAY : S_D_PUSH;
      S_D_PUSH:    state_d = S_D_POP;
      S_REPLAY:    state_d = q_empty ? S_DONE : S_R_OUT;
      S_R_OUT:     state_d = S_REPLAY;
      default:     state_d = S_IDLE;
    endcase

    // Output flags are decoded from the next state so they line up with the state register.
    ctl_d           = '0;
    ctl_d.init      = (state_d == S_INIT);
    ctl_d.probe     = (state_d == S_PROBE);
    ctl_d.bound     = (state_d == S_BOUND);
    ctl_d.move      = (state_d == S_MOVE);
    ctl_d.mark      = (state_d == S_MARK);
    ctl_d.next_dir  = (state_d == S_NEXT_DIR);
    ctl_d.back      = (state_d == S_BACK);
    ctl_d.back_dir  = (state_d == S_BACK_DIR);
    ctl_d.back_move = (state_d == S_BACK_MOVE);
    ctl_d.restore   = (state_d == S_RESTORE);
    ctl_d.d_pop     = (state_d == S_D_POP);
    ctl_d.d_push    = (state_d == S_D_PUSH);
    ctl_d.replay    = (state_d == S_REPLAY);
    ctl_d.r_out     = (state_d == S_R_OUT);
    ctl_d.done      = (state_d == S_DONE);
    ctl_d.fail      = (state_d == S_FAIL);
    ctl_d.busy      = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // Strobes whose assertion depends on a same-cycle datapath flag are gated here.
  assign adv_dir    = ctl_q.next_dir & ~dir_ends;
  assign ld_x       = (ctl_q.move | ctl_q.back_move) & xy_select;
  assign ld_y       = (ctl_q.move | ctl_q.back_move) & ~xy_select;
  assign ld_n_x     = ctl_q.probe & xy_select;
  assign ld_n_y     = ctl_q.probe & ~xy_select;
  assign ld_dir     = adv_dir | ctl_q.back_dir | ctl_q.restore;
  assign dir_select = ctl_q.restore ? 2'd2 : (adv_dir ? 2'd1 : 2'd0);
  assign rst_x      = ctl_q.init;
  assign rst_y      = ctl_q.init;
  assign rst_n_x    = ctl_q.init;
  assign rst_n_y    = ctl_q.init;
  assign rst_dir    = ctl_q.init | ctl_q.mark;
  assign mem_rd     = ctl_q.bound & ~wall;
  assign mem_select = ctl_q.bound & ~wall;
  assign mem_wr     = ctl_q.init | ctl_q.mark;
  assign mem_din    = ctl_q.init | ctl_q.mark;
  assign stack_wr   = ctl_q.move;
  assign stack_rd   = (ctl_q.back | ctl_q.d_pop) & ~stack_empty;
  assign q_wr       = ctl_q.d_push;
  assign q_rd       = ctl_q.replay & ~q_empty;
  assign busy       = ctl_q.busy;
  assign done       = ctl_q.done;
  assign fail       = ctl_q.fail;
  assign move_valid = ctl_q.r_out;

endmodule

// File: tb/tb_maze_controller.sv
// Bench for maze_controller: an in-bench datapath and maze memory, directed and random mazes,
// and a scoreboard fed by a plain depth-first search over the grid.
module tb_maze_controller;

  localparam int BUDGET = 15000;

  logic clk = 1'b0;
  logic rst, start;
  logic dir_ends, arrive_final, wall, stack_empty, q_empty, xy_select, mem_dout;
  logic ld_x, ld_y, ld_dir, ld_n_x, ld_n_y;
  logic rst_x, rst_y, rst_dir, rst_n_x, rst_n_y;
  logic [1:0] dir_select;
  logic mem_select, mem_rd, mem_wr, mem_din;
  logic stack_rd, stack_wr, q_rd, q_wr;
  logic busy, done, fail, move_valid;

  maze_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .dir_ends(dir_ends), .arrive_final(arrive_final), .wall(wall),
    .stack_empty(stack_empty), .q_empty(q_empty), .xy_select(xy_select), .mem_dout(mem_dout),
    .ld_x(ld_x), .ld_y(ld_y), .ld_dir(ld_dir), .ld_n_x(ld_n_x), .ld_n_y(ld_n_y),
    .rst_x(rst_x), .rst_y(rst_y), .rst_dir(rst_dir), .rst_n_x(rst_n_x), .rst_n_y(rst_n_y),
    .dir_select(dir_select), .mem_select(mem_select), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_din(mem_din), .stack_rd(stack_rd), .stack_wr(stack_wr), .q_rd(q_rd), .q_wr(q_wr),
    .busy(busy), .done(done), .fail(fail), .move_valid(move_valid)
  );

  always #5 clk = ~clk;

  // Datapath model. Directions: 0 east (+x), 1 north (-y), 2 south (+y), 3 west (-x); reverse is 3-d.
  logic [3:0] dp_x, dp_y, dp_nx, dp_ny;
  logic [1:0] dp_dir, dp_top, dp_move;
  logic       dp_rdata;
  logic       maze [16][16];
  logic       maze_init [16][16];
  logic [1:0] stk [256];
  logic [1:0] qm [256];
  logic [8:0] sp;
  logic [7:0] qh, qt;
  logic       load_maze;

  assign xy_select    = (dp_dir == 2'd0) || (dp_dir == 2'd3);
  assign dir_ends     = (dp_dir == 2'd3);
  assign arrive_final = (dp_x == 4'd15) && (dp_y == 4'd15);
  assign wall         = (dp_dir == 2'd0 && dp_x == 4'd15) || (dp_dir == 2'd1 && dp_y == 4'd0) ||
                        (dp_dir == 2'd2 && dp_y == 4'd15) || (dp_dir == 2'd3 && dp_x == 4'd0);
  assign stack_empty  = (sp == 9'd0);
  assign q_empty      = (qh == qt);
  assign mem_dout     = dp_rdata;

  always @(posedge clk) begin
    if (load_maze) begin
      for (int yy = 0; yy < 16; yy++)
        for (int xx = 0; xx < 16; xx++)
          maze[yy][xx] <= maze_init[yy][xx];
      sp <= '0; qh <= '0; qt <= '0;
      dp_x <= '0; dp_y <= '0; dp_nx <= '0; dp_ny <= '0; dp_dir <= '0;
      dp_top <= '0; dp_move <= '0; dp_rdata <= 1'b0;
    end else begin
      if (rst_x) dp_x <= '0;
      else if (ld_x) dp_x <= (dp_dir == 2'd0) ? dp_x + 4'd1 : dp_x - 4'd1;
      if (rst_y) dp_y <= '0;
      else if (ld_y) dp_y <= (dp_dir == 2'd2) ? dp_y + 4'd1 : dp_y - 4'd1;
      if (rst_n_x) dp_nx <= '0;
      else if (ld_n_x) dp_nx <= (dp_dir == 2'd0) ? dp_x + 4'd1 : dp_x - 4'd1;
      else if (ld_n_y) dp_nx <= dp_x;
      if (rst_n_y) dp_ny <= '0;
      else if (ld_n_y) dp_ny <= (dp_dir == 2'd2) ? dp_y + 4'd1 : dp_y - 4'd1;
      else if (ld_n_x) dp_ny <= dp_y;
      if (rst_dir) dp_dir <= '0;
      else if (ld_dir) begin
        case (dir_select)
          2'd0:    dp_dir <= 2'd3 - dp_top;
          2'd1:    dp_dir <= dp_dir + 2'd1;
          default: dp_dir <= 2'd3 - dp_dir;
        endcase
      end
      if (mem_wr) begin
        if (mem_select) maze[dp_ny][dp_nx] <= mem_din;
        else maze[rst_y ? 4'd0 : dp_y][rst_x ? 4'd0 : dp_x] <= mem_din;
      end
      if (mem_rd) dp_rdata <= mem_select ? maze[dp_ny][dp_nx] : maze[dp_y][dp_x];
      if (stack_wr) begin
        stk[sp[7:0]] <= dp_dir;
        sp <= sp + 9'd1;
      end else if (stack_rd) begin
        dp_top <= stk[sp[7:0] - 8'd1];
        sp <= sp - 9'd1;
      end
      if (q_wr) begin
        qm[qt] <= dp_top;
        qt <= qt + 8'd1;
      end
      if (q_rd) begin
        dp_move <= qm[qh];
        qh <= qh + 8'd1;
      end
    end
  end

  int checks = 0, errors = 0;
  int end_count = 0, cyc = 0, last_mv = -10;
  int bt_cnt = 0, sw_cnt = 0, mv0 = 0, mv2 = 0, mv_cnt = 0;
  int exp_bt = 0, exp_sw = 0;
  bit mon_en = 1'b0;
  int exp_moves [$];
  bit exp_result [$];

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  function automatic int dxOf(input int d);
    return (d == 0) ? 1 : ((d == 3) ? -1 : 0);
  endfunction

  function automatic int dyOf(input int d);
    return (d == 2) ? 1 : ((d == 1) ? -1 : 0);
  endfunction

  // Reference search: recursive DFS over the grid, trying directions 0..3 from each cell.
  task automatic buildExpected();
    bit vis [16][16];
    int pd [256];
    int nd [257];
    int depth, cx, cy, d, nx, ny, bts, fwd;
    bit found, ok, stop;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        vis[yy][xx] = maze_init[yy][xx];
    cx = 0; cy = 0; vis[0][0] = 1'b1; depth = 0; nd[0] = 0; bts = 0; fwd = 0;
    ok = 1'b0; stop = 1'b0;
    for (int it = 0; it < 8192 && !stop; it++) begin
      if (cx == 15 && cy == 15) begin
        ok = 1'b1; stop = 1'b1;
      end else begin
        found = 1'b0;
        while (nd[depth] < 4 && !found) begin
          d = nd[depth]; nd[depth]++;
          nx = cx + dxOf(d); ny = cy + dyOf(d);
          if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[ny][nx]) begin
            vis[ny][nx] = 1'b1; pd[depth] = d; depth++; nd[depth] = 0;
            cx = nx; cy = ny; found = 1'b1; fwd++;
          end
        end
        if (!found) begin
          if (depth == 0) stop = 1'b1;
          else begin
            depth--; bts++; d = pd[depth];
            cx = cx - dxOf(d); cy = cy - dyOf(d);
          end
        end
      end
    end
    // The stack drains top-first into the queue, so replay shows the path last move first.
    for (int k = depth - 1; k >= 0; k--) exp_moves.push_back(pd[k]);
    exp_result.push_back(ok);
    exp_bt = bts;
    exp_sw = fwd;
  endtask

  initial begin : monitor
    int e;
    bit fin, fin_prev, d1, d2, sr1;
    fin_prev = 1'b0; d1 = 1'b0; d2 = 1'b0; sr1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      fin = done | fail;
      if (rst_x) begin
        bt_cnt = 0; sw_cnt = 0; mv0 = 0; mv2 = 0; mv_cnt = 0;
      end
      if (!mon_en) begin
        d1 = 1'b0; d2 = 1'b0; sr1 = 1'b0;
      end else begin
        if (stack_rd | stack_wr | q_rd | q_wr | mem_rd | mem_wr)
          checkOutput("strobe_excl", {stack_rd & stack_wr, q_rd & q_wr, mem_rd & mem_wr}, 0);
        if (mem_wr | mem_din) checkOutput("mem_din", mem_din, mem_wr);
        if (stack_wr) sw_cnt++;
        if (move_valid) begin
          checkOutput("mv_gap", (cyc - last_mv) >= 2, 1);
          last_mv = cyc;
          mv_cnt++;
          if (dp_move == 2'd0) mv0++;
          if (dp_move == 2'd2) mv2++;
          if (exp_moves.size() == 0) checkOutput("mv_extra", 1, 0);
          else begin
            e = exp_moves.pop_front();
            checkOutput("move", dp_move, e);
          end
        end
        if (sr1) checkOutput("after_pop", (ld_dir && dir_select == 2'd0) || q_wr, 1);
        if (d2) checkOutput("restore_dir", ld_dir && dir_select == 2'd2, 1);
        d2 = d1;
        d1 = ld_dir && (dir_select == 2'd0);
        if (d1) bt_cnt++;
        sr1 = stack_rd;
        if (fin && !fin_prev) begin
          if (exp_result.size() == 0) checkOutput("end_extra", 1, 0);
          else begin
            e = int'(exp_result.pop_front());
            checkOutput("done", done, e);
            checkOutput("fail", fail, (e == 0) ? 1 : 0);
          end
          checkOutput("moves_left", exp_moves.size(), 0);
          checkOutput("backtracks", bt_cnt, exp_bt);
          checkOutput("stack_writes", sw_cnt, exp_sw);
          checkOutput("busy_end", busy, 0);
          end_count++;
        end
      end
      fin_prev = fin;
    end
  end

  task automatic loadMaze();
    @(negedge clk) load_maze = 1'b1;
    @(negedge clk) load_maze = 1'b0;
  endtask

  task automatic resetDut();
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_moves.delete();
    exp_result.delete();
  endtask

  task automatic fillMaze(input bit v);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        maze_init[yy][xx] = v;
  endtask

  task automatic applyStimulus(input string name);
    int e0;
    bit got;
    loadMaze();
    buildExpected();
    mon_en = 1'b1;
    e0 = end_count; got = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(posedge clk); #2;
      if (end_count != e0) got = 1'b1;
    end
    checkOutput({name, "_finished"}, got, 1);
    if (!got) resetDut();
  endtask

  function automatic logic [23:0] allOuts();
    return {ld_x, ld_y, ld_dir, ld_n_x, ld_n_y, rst_x, rst_y, rst_dir, rst_n_x, rst_n_y,
            dir_select, mem_select, mem_rd, mem_wr, mem_din, stack_rd, stack_wr,
            q_rd, q_wr, busy, done, fail, move_valid};
  endfunction

  initial begin : stimulus
    bit got, clean;
    int inits, e0;
    rst = 1'b1; start = 1'b0; load_maze = 1'b0;
    fillMaze(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_outs", allOuts(), 0);
    rst = 1'b0;

    // Reset held for two cycles while in MOVE, then a clean start.
    loadMaze();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #2;
      if (stack_wr) got = 1'b1;
    end
    checkOutput("move_reached", got, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("rst_in_move_outs", allOuts(), 0);
    @(posedge clk); #2;
    checkOutput("rst_hold_outs", allOuts(), 0);
    rst = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #2;
    checkOutput("init_outs", {rst_x, rst_y, rst_dir, rst_n_x, rst_n_y, mem_wr, mem_din,
                              mem_select, busy, stack_wr}, 10'b1111111010);
    start = 1'b0;
    resetDut();

    fillMaze(1'b0);
    applyStimulus("free");
    checkOutput("free_done", done, 1);
    checkOutput("free_east_moves", mv0, 15);
    checkOutput("free_south_moves", mv2, 15);

    fillMaze(1'b0);
    maze_init[0][1] = 1'b1;
    maze_init[1][0] = 1'b1;
    applyStimulus("enclosed");
    checkOutput("enclosed_fail", fail, 1);
    checkOutput("enclosed_no_push", sw_cnt, 0);
    checkOutput("enclosed_stack_empty", stack_empty, 1);

    fillMaze(1'b1);
    maze_init[0][1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      maze_init[k][0]  = 1'b0;
      maze_init[15][k] = 1'b0;
    end
    applyStimulus("deadend");
    checkOutput("deadend_backtracks", bt_cnt, 1);
    checkOutput("deadend_moves", mv_cnt, 30);

    for (int r = 0; r < 5; r++) begin
      for (int yy = 0; yy < 16; yy++)
        for (int xx = 0; xx < 16; xx++)
          maze_init[yy][xx] = ($urandom_range(0, 99) < 28);
      maze_init[0][0] = 1'b0;
      maze_init[15][15] = 1'b0;
      applyStimulus("random");
    end

    // Start held high for the whole run: only one INIT until DONE, then a restart.
    fillMaze(1'b0);
    loadMaze();
    buildExpected();
    mon_en = 1'b1;
    inits = 0; e0 = end_count; got = 1'b0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(posedge clk); #2;
      if (rst_x) inits++;
      if (end_count != e0) got = 1'b1;
    end
    mon_en = 1'b0;
    checkOutput("busy_finished", got, 1);
    checkOutput("busy_single_init", inits, 1);
    checkOutput("busy_done", done, 1);
    @(posedge clk); #2;
    checkOutput("restart_init", {rst_x, rst_y, rst_dir, rst_n_x, rst_n_y, busy, done}, 7'b1111110);
    start = 1'b0;
    resetDut();

    // Reset during the drain phase.
    fillMaze(1'b0);
    loadMaze();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(posedge clk); #2;
      if (q_wr) got = 1'b1;
    end
    checkOutput("drain_reached", got, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("rst_in_drain_outs", allOuts(), 0);
    @(negedge clk) rst = 1'b0;
    clean = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (q_wr || move_valid || busy) clean = 1'b0;
    end
    checkOutput("post_drain_reset_quiet", clean, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
